mc_risc_core: RTL and testbench

Parametrised multicycle successor to the single-cycle 11-bit RISC processor. It keeps the same 3-bit-opcode ISA and generalises data width, register count, immediate width and PC width. It adds request/acknowledge handshakes to instruction and data memory, so that memory latency can vary. It also adds a resettable register file, a same-instruction beq compare and a halt opcode. The core sits between the top-level testbench/SoC and external imem/dmem models.

---
 rtl/mc_risc_mem_if.sv | 27 ++
 rtl/mc_risc_core.sv | 119 +++++++++++
 tb/tb_mc_risc_core.sv | 214 +++++++++++++++++++++
 3 files changed

// File: rtl/mc_risc_mem_if.sv
// rtl/mc_risc_mem_if.sv - instruction/data memory request-acknowledge bus of mc_risc_core
interface mc_risc_mem_if #(
    parameter int DATA_W  = 8,
    parameter int PC_W    = 8,
    parameter int INSTR_W = 11
);
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_ack;
    logic [INSTR_W-1:0] imem_rdata;
    logic               dmem_req;
    logic               dmem_we;
    logic [DATA_W-1:0]  dmem_addr;
    logic [DATA_W-1:0]  dmem_wdata;
    logic               dmem_ack;
    logic [DATA_W-1:0]  dmem_rdata;

    modport master (
        output imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        input  imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );

    modport slave (
        input  imem_req, imem_addr, dmem_req, dmem_we, dmem_addr, dmem_wdata,
        output imem_ack, imem_rdata, dmem_ack, dmem_rdata
    );
endinterface

// File: rtl/mc_risc_core.sv
// rtl/mc_risc_core.sv - parametrised multicycle 3-bit-opcode RISC core with handshaked memories
module mc_risc_core #(
    parameter int DATA_W = 8,
    parameter int REG_AW = 2,
    parameter int IMM_W  = 4,
    parameter int PC_W   = 8
) (
    input  logic            clk,
    input  logic            reset,
    mc_risc_mem_if.master   mem,
    output logic [PC_W-1:0] pc,
    output logic            halted
);
    localparam int INSTR_W = 3 + 2 * REG_AW + IMM_W;
    localparam int NREGS   = 2 ** REG_AW;

    typedef enum logic [1:0] {FETCH, EXEC, MEM, HALT} state_t;

    state_t             state;
    logic [INSTR_W-1:0] ir;
    logic [DATA_W-1:0]  regs [NREGS];

    logic [2:0]         opcode;
    logic [REG_AW-1:0]  rd, ra, rb;
    logic [IMM_W-1:0]   imm;
    logic [1:0]         aluop;
    logic [DATA_W-1:0]  rd_val, ra_val, rb_val, alu_res, ea;
    logic [PC_W-1:0]    pc_inc;

    assign opcode = ir[INSTR_W-1 -: 3];
    assign rd     = ir[INSTR_W-4 -: REG_AW];
    assign ra     = ir[INSTR_W-4-REG_AW -: REG_AW];
    assign imm    = ir[IMM_W-1:0];
    assign rb     = imm[REG_AW+1:2];
    assign aluop  = imm[1:0];

    assign rd_val = regs[rd];
    assign ra_val = regs[ra];
    assign rb_val = regs[rb];
    assign ea     = ra_val + DATA_W'(imm);
    assign pc_inc = pc + PC_W'(1);

    assign mem.imem_addr = pc;

    always_comb begin
        alu_res = '0;
        case (aluop)
            2'b00:   alu_res = ra_val + rb_val;
            2'b01:   alu_res = ra_val + ~rb_val + DATA_W'(1);
            2'b10:   alu_res = ra_val & rb_val;
            default: alu_res = ra_val | rb_val;
        endcase
    end

    // imem_req is registered, so the first FETCH after reset spends one idle cycle raising it.
    always_ff @(posedge clk) begin
        if (!reset) begin
            state          <= FETCH;
            pc             <= '0;
            ir             <= '0;
            halted         <= 1'b0;
            mem.imem_req   <= 1'b0;
            mem.dmem_req   <= 1'b0;
            mem.dmem_we    <= 1'b0;
            mem.dmem_addr  <= '0;
            mem.dmem_wdata <= '0;
            for (int i = 0; i < NREGS; i++) regs[i] <= '0;
        end else begin
            case (state)
                FETCH: begin
                    if (!mem.imem_req) begin
                        mem.imem_req <= 1'b1;
                    end else if (mem.imem_ack) begin
                        ir           <= mem.imem_rdata;
                        mem.imem_req <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    state        <= FETCH;
                    mem.imem_req <= 1'b1;
                    pc           <= pc_inc;
                    case (opcode)
                        3'b000: regs[rd] <= alu_res;
                        3'b001: regs[rd] <= ea;
                        3'b010, 3'b011: begin
                            mem.dmem_addr  <= ea;
                            mem.dmem_we    <= opcode[0];
                            mem.dmem_wdata <= rd_val;
                            mem.dmem_req   <= 1'b1;
                            mem.imem_req   <= 1'b0;
                            pc             <= pc;
                            state          <= MEM;
                        end
                        3'b100: if (rd_val == ra_val) pc <= pc + PC_W'($signed(imm));
                        3'b101: pc <= PC_W'(ir[INSTR_W-4:0]);
                        3'b110: regs[rd] <= DATA_W'(imm);
                        default: begin
                            mem.imem_req <= 1'b0;
                            pc           <= pc;
                            halted       <= 1'b1;
                            state        <= HALT;
                        end
                    endcase
                end
                MEM: begin
                    if (mem.dmem_req && mem.dmem_ack) begin
                        if (!mem.dmem_we) regs[rd] <= mem.dmem_rdata;
                        mem.dmem_req <= 1'b0;
                        mem.imem_req <= 1'b1;
                        pc           <= pc_inc;
                        state        <= FETCH;
                    end
                end
                default: ;
            endcase
        end
    end
endmodule

// File: tb/tb_mc_risc_core.sv
// tb/tb_mc_risc_core.sv - directed self-checking bench for mc_risc_core
module tb_mc_risc_core;
    logic clk = 1'b0;
    logic reset = 1'b0;
    always #5 clk = ~clk;

    int tests = 0;
    int failed = 0;

    logic [10:0] prog  [256];
    logic [10:0] prog4 [256];
    logic [7:0]  dram  [256];
    int          dmem_delay = 3;
    int          dcnt = 0;
    logic        dack_force = 1'b0;

    mc_risc_mem_if #(.DATA_W(8), .PC_W(8), .INSTR_W(11)) m ();
    mc_risc_mem_if #(.DATA_W(4), .PC_W(8), .INSTR_W(11)) m4 ();
    logic [7:0] pc, pc4;
    logic       halted, halted4;

    mc_risc_core #(.DATA_W(8), .REG_AW(2), .IMM_W(4), .PC_W(8)) dut (
        .clk(clk), .reset(reset), .mem(m), .pc(pc), .halted(halted)
    );
    mc_risc_core #(.DATA_W(4), .REG_AW(2), .IMM_W(4), .PC_W(8)) dut4 (
        .clk(clk), .reset(reset), .mem(m4), .pc(pc4), .halted(halted4)
    );

    assign m.imem_ack   = m.imem_req;
    assign m.imem_rdata = prog[m.imem_addr];
    assign m.dmem_ack   = dack_force | (m.dmem_req && (dcnt == dmem_delay));
    assign m.dmem_rdata = dram[m.dmem_addr];

    assign m4.imem_ack   = m4.imem_req;
    assign m4.imem_rdata = prog4[m4.imem_addr];
    assign m4.dmem_ack   = m4.dmem_req;
    assign m4.dmem_rdata = 4'h0;

    always @(posedge clk) begin
        if (!m.dmem_req || m.dmem_ack) dcnt <= 0;
        else dcnt <= dcnt + 1;
        if (m.dmem_req && m.dmem_ack && m.dmem_we) dram[m.dmem_addr] <= m.dmem_wdata;
    end

    function automatic logic [10:0] ins(input logic [2:0] op, input logic [1:0] rd,
                                        input logic [1:0] ra, input logic [3:0] imm);
        return {op, rd, ra, imm};
    endfunction

    function automatic logic [10:0] jmp(input logic [7:0] tgt);
        return {3'b101, tgt};
    endfunction

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        tests++;
        assert (obs === exp)
        else begin
            failed++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Runs until pc moves away from its current value (bounded) and checks where it landed.
    task automatic step_pc(input string tag, input logic [7:0] exp);
        logic [7:0] p0;
        int n;
        p0 = pc;
        n = 0;
        while (pc == p0 && n < 30) begin
            tick(1);
            n++;
        end
        chk(tag, 32'(pc), 32'(exp));
    endtask

    initial begin
        int n, reqcnt;
        for (int i = 0; i < 256; i++) begin
            prog[i]  = 11'h0;
            prog4[i] = 11'h0;
            dram[i]  = 8'h0;
        end
        prog[0]    = ins(3'b110, 2'd1, 2'd0, 4'd5);
        prog[1]    = ins(3'b110, 2'd2, 2'd0, 4'd3);
        prog[2]    = ins(3'b000, 2'd3, 2'd1, 4'b1001);
        prog[3]    = ins(3'b011, 2'd1, 2'd2, 4'd2);
        prog[4]    = ins(3'b010, 2'd2, 2'd1, 4'd0);
        prog[5]    = jmp(8'h0A);
        prog[8]    = ins(3'b110, 2'd2, 2'd0, 4'd9);
        prog[9]    = ins(3'b001, 2'd0, 2'd0, 4'd0);
        prog[10]   = ins(3'b100, 2'd1, 2'd2, 4'b1110);
        prog[11]   = jmp(8'h7F);
        prog[8'h7F] = jmp(8'hFF);
        prog[8'hFF] = ins(3'b110, 2'd0, 2'd0, 4'd1);

        prog4[0] = ins(3'b001, 2'd0, 2'd0, 4'hF);
        prog4[1] = ins(3'b001, 2'd0, 2'd0, 4'hF);
        prog4[2] = ins(3'b110, 2'd1, 2'd0, 4'd3);
        prog4[3] = ins(3'b110, 2'd2, 2'd0, 4'd5);
        prog4[4] = ins(3'b000, 2'd3, 2'd1, 4'b1001);
        prog4[5] = ins(3'b111, 2'd0, 2'd0, 4'd0);

        tick(2);
        chk("rst_pc", 32'(pc), 0);
        chk("rst_imem_req", 32'(m.imem_req), 0);
        chk("rst_dmem_req", 32'(m.dmem_req), 0);
        chk("rst_dmem_we", 32'(m.dmem_we), 0);
        chk("rst_dmem_addr", 32'(m.dmem_addr), 0);
        chk("rst_dmem_wdata", 32'(m.dmem_wdata), 0);
        chk("rst_halted", 32'(halted), 0);
        chk("rst_r3", 32'(dut.regs[3]), 0);

        reset = 1'b1;
        tick(1);
        chk("fetch_req", 32'(m.imem_req), 1);
        chk("fetch_pc", 32'(pc), 0);
        tick(2);
        chk("init_r1_pc", 32'(pc), 1);
        chk("init_r1", 32'(dut.regs[1]), 5);
        tick(2);
        chk("init_r2_pc", 32'(pc), 2);
        chk("init_r2", 32'(dut.regs[2]), 3);
        tick(2);
        chk("sub_pc", 32'(pc), 3);
        chk("sub_r3", 32'(dut.regs[3]), 2);

        tick(2);
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("sw_req_%0d", k), 32'(m.dmem_req), 1);
            chk($sformatf("sw_we_%0d", k), 32'(m.dmem_we), 1);
            chk($sformatf("sw_addr_%0d", k), 32'(m.dmem_addr), 5);
            chk($sformatf("sw_wdata_%0d", k), 32'(m.dmem_wdata), 5);
            chk($sformatf("sw_no_imem_%0d", k), 32'(m.imem_req), 0);
            tick(1);
        end
        chk("sw_req_drop", 32'(m.dmem_req), 0);
        chk("sw_pc", 32'(pc), 4);
        chk("sw_mem", 32'(dram[5]), 5);

        dmem_delay = 1;
        tick(2);
        chk("lw_req", 32'(m.dmem_req), 1);
        chk("lw_we", 32'(m.dmem_we), 0);
        chk("lw_addr", 32'(m.dmem_addr), 5);
        step_pc("lw_pc", 8'd5);
        chk("lw_r2", 32'(dut.regs[2]), 5);

        step_pc("j_0a", 8'd10);
        step_pc("beq_eq", 8'd8);
        step_pc("init_pc9", 8'd9);
        chk("init_r2_9", 32'(dut.regs[2]), 9);
        step_pc("addi0_pc", 8'd10);
        step_pc("beq_ne", 8'd11);
        step_pc("j_7f", 8'h7F);
        prog[0] = ins(3'b111, 2'd0, 2'd0, 4'd0);
        step_pc("j_ff", 8'hFF);
        step_pc("pc_wrap", 8'd0);
        chk("wrap_r0", 32'(dut.regs[0]), 1);

        n = 0;
        while (!halted && n < 10) begin
            tick(1);
            n++;
        end
        chk("halted", 32'(halted), 1);
        reqcnt = 0;
        for (int k = 0; k < 20; k++) begin
            tick(1);
            if (m.imem_req || m.dmem_req) reqcnt++;
        end
        chk("halt_no_req", 32'(reqcnt), 0);
        chk("halt_pc", 32'(pc), 0);

        chk("w4_halted", 32'(halted4), 1);
        chk("w4_r0_wrap", 32'(dut4.regs[0]), 32'hE);
        chk("w4_sub", 32'(dut4.regs[3]), 32'hE);
        chk("w4_pc", 32'(pc4), 5);

        reset = 1'b0;
        prog[0] = ins(3'b110, 2'd1, 2'd0, 4'd5);
        prog[1] = ins(3'b010, 2'd3, 2'd1, 4'd0);
        dmem_delay = 10;
        tick(1);
        chk("rst2_halted", 32'(halted), 0);
        reset = 1'b1;
        n = 0;
        while (!m.dmem_req && n < 20) begin
            tick(1);
            n++;
        end
        chk("mid_mem_req", 32'(m.dmem_req), 1);
        chk("mid_mem_r1", 32'(dut.regs[1]), 5);
        reset = 1'b0;
        dack_force = 1'b1;
        tick(1);
        dack_force = 1'b0;
        chk("rst_mem_r3", 32'(dut.regs[3]), 0);
        chk("rst_mem_r1", 32'(dut.regs[1]), 0);
        chk("rst_mem_pc", 32'(pc), 0);
        chk("rst_mem_state", 32'(dut.state), 0);
        chk("rst_mem_dreq", 32'(m.dmem_req), 0);
        chk("rst_mem_ireq", 32'(m.imem_req), 0);
        reset = 1'b1;
        tick(2);

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule
